freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
// - Measures the frequency of an external square wave; the counterpart to frequency_divider, which generates clocks from clk_50MHz.
// - Counts rising edges of sig_in over a fixed gate window timed from clk_50MHz.
// - Latches the count as packed BCD for the display/LED logic in the lab top level.
// - With GATE_CYCLES = 50_000_000, the result reads directly in Hz.
// PARAMETERS
// - GATE_CYCLES  50_000_000  gate window length in clk_50MHz cycles (>= 4)
// - DIGITS       6           BCD digits in count/result (1..8)
// - SCAN_CYCLES  50_000      clk cycles per display digit (FREQ_METER_SCAN_EN only)
// PORTS
// - clk_50MHz  in   1          system clock; the only clock
// - rst        in   1          synchronous reset, active-high
// - sig_in     in   1          measured signal, asynchronous to clk_50MHz
// - hold       in   1          1 = freeze result/ovf at window end (counting continues)
// - result     out  4*DIGITS   packed BCD count of the last completed window
// - ovf        out  1          last completed window saturated
// - valid      out  1          1-cycle pulse: result/ovf just updated
// - sel        out  8          digit select, active-low (FREQ_METER_SCAN_EN only)
// - seg        out  8          segments {dp,g..a}, active-low (FREQ_METER_SCAN_EN only)
// BEHAVIOUR
// - rst=1 at a clk edge clears all state:
//   - sync regs, edge reg, gate counter, BCD count, sat flag -> 0
//   - result=0, ovf=0, valid=0, sel=8'hFF, seg=8'hFF
//   - first window starts the cycle after rst deasserts
//   - rst mid-window discards the partial count; no valid is issued
// - Sync: sig_in -> s1 -> s2 (2-FF), s3 <= s2; edge = s2 & ~s3.
//   - edge asserts 3 clk edges after a sig_in rise.
//   - Pulses shorter than 1 clk period may be missed.
// - Gate counter: 0..GATE_CYCLES-1, wraps to 0; each wrap ends one window.
// - BCD count: DIGITS-digit decimal counter, +1 per edge.
//   - Ripple carry digit 9->0.
//   - At all-9s, a further edge leaves count at all-9s and sets the sat flag.
// - FSM with 2 states, COUNT and LATCH:
//   - COUNT: last gate cycle -> LATCH, taking result <= count (+ that cycle's edge), ovf <= sat, count <= 0, sat <= 0.
//     - With hold=1, result/ovf are not written; count and sat still clear.
//   - LATCH (exactly 1 cycle): valid=1 only if the transfer occurred, then -> COUNT.
//     - The gate counter keeps running.
//     - An edge in this cycle counts toward the new window.
//   - valid period = GATE_CYCLES cycles; window-to-window edge accounting is lossless.
// CONFIGURATION
// - FREQ_METER_SCAN_EN defined:
//   - sel/seg ports and a multiplexed 7-seg driver are compiled in.
//   - Digit pointer advances every SCAN_CYCLES over digits 0..DIGITS-1 (digit 0 -> sel[0]=0).
//   - Unused sel bits stay 1; dp is on (seg[7]=0) for digit 0 when ovf=1.
//   - Segments decode from result; codes 0..9 standard, >9 blank.
// - Undefined: sel/seg and the driver are absent; all other behaviour is identical.
// TESTING (GATE_CYCLES=1000, DIGITS=3 unless noted)
// 1. sig_in period 10 clk, 50% duty -> every valid: result=12'h100, ovf=0, valid spacing 1000 cycles.
// 2. DIGITS=2, 150 edges per window -> result=8'h99, ovf=1; next window 40 edges -> result=8'h40, ovf=0.
// 3. sig_in rise placed so edge lands on the last gate cycle, then on the LATCH cycle -> counted in closing window, then in next window; total over 3 windows = exact edge count.
// 4. rst=1 for 2 cycles at gate cycle 500 -> result=0, ovf=0, valid=0; first valid after rst deasserts arrives 1000 cycles later.
// 5. hold=1 across one window end -> no valid, result unchanged; hold=0 -> next window updates normally.
// 6. FREQ_METER_SCAN_EN, SCAN_CYCLES=4, result=12'h127 -> sel cycles FE,FD,FB; seg = 8'hF8, 8'hA4, 8'hF9.

Source files
------------

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over a GATE_CYCLES window, latches packed BCD; optional FREQ_METER_SCAN_EN 7-seg scan.
// Latency: sig_in rise counted on the 3rd clk edge; result/ovf/valid update one cycle after the last gate cycle.
// Backpressure: none; valid is a 1-cycle pulse, hold freezes result/ovf while counting continues.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DIGITS      = 6
`ifdef FREQ_METER_SCAN_EN
  ,
  parameter int SCAN_CYCLES = 50_000
`endif
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic                sig_in,
  input  logic                hold,
  output logic [4*DIGITS-1:0] result,
  output logic                ovf,
  output logic                valid
`ifdef FREQ_METER_SCAN_EN
  ,
  output logic [7:0]          sel,
  output logic [7:0]          seg
`endif
);

  localparam int GW = $clog2(GATE_CYCLES);

  typedef enum logic {COUNT, LATCH} state_t;

  state_t              state;
  logic                s1, s2, s3;
  logic                sig_rise;
  logic [GW-1:0]       gcnt;
  logic                last_gate;
  logic [4*DIGITS-1:0] count, count_inc, count_n;
  logic                sat, sat_n;
  logic                carry;

  assign sig_rise  = s2 & ~s3;
  assign last_gate = (gcnt == GW'(GATE_CYCLES - 1));

  // Ripple BCD increment; a carry out of the top digit means all-9s, so saturate instead.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    count_n = count;
    sat_n   = sat;
    if (sig_rise) begin
      if (carry) sat_n = 1'b1;
      else       count_n = count_inc;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      gcnt   <= '0;
      count  <= '0;
      sat    <= 1'b0;
      state  <= COUNT;
      result <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      gcnt  <= last_gate ? '0 : gcnt + GW'(1);
      valid <= 1'b0;
      count <= count_n;
      sat   <= sat_n;
      case (state)
        COUNT: begin
          if (last_gate) begin
            // The closing cycle's edge goes into result; the new window starts empty.
            state <= LATCH;
            count <= '0;
            sat   <= 1'b0;
            if (!hold) begin
              result <= count_n;
              ovf    <= sat_n;
              valid  <= 1'b1;
            end
          end
        end
        LATCH:   state <= COUNT;
        default: state <= COUNT;
      endcase
    end
  end

`ifdef FREQ_METER_SCAN_EN
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [SW-1:0] scan_cnt;
  logic [2:0]    dig;
  logic [3:0]    cur;

  assign cur = result[4*dig +: 4];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      scan_cnt <= '0;
      dig      <= 3'd0;
      sel      <= 8'hFF;
      seg      <= 8'hFF;
    end else begin
      if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
        scan_cnt <= '0;
        dig      <= (dig == 3'(DIGITS - 1)) ? 3'd0 : dig + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      sel <= ~(8'h01 << dig);
      seg <= {~((dig == 3'd0) & ovf), ~seg7(cur)};
    end
  end
`endif

endmodule
